// File: rtl/round_key_sequencer.sv
// Round-key sequencer: registers a cipher key, captures the full key schedule
// into a local bank, then streams the round keys in forward or reverse order.
module round_key_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128,
  localparam int IDX_W     = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            key_load,
  input  logic [KEY_W-1:0]                key_in,
  output logic [KEY_W-1:0]                key_out,
  input  logic [(NUM_ROUNDS+1)*KEY_W-1:0] round_keys_in,
  input  logic                            start,
  input  logic                            decrypt,
  output logic [KEY_W-1:0]                rk_data,
  output logic [IDX_W-1:0]                rk_round,
  output logic                            rk_valid,
  input  logic                            rk_ready,
  output logic                            key_ready,
  output logic                            done
);

  typedef enum logic [2:0] {IDLE, CAPTURE, READY, STREAM, DONE} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

  state_e           state_q;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] bank_q [NUM_ROUNDS+1];
  logic [IDX_W-1:0] idx_q;
  logic             dir_q;
  logic             valid_q;
  logic             key_ready_q;
  logic             done_q;
  logic             last_key;

  // The final key depends on direction: top index forward, zero in reverse.
  assign last_key = dir_q ? (idx_q == '0) : (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      idx_q       <= '0;
      dir_q       <= 1'b0;
      valid_q     <= 1'b0;
      key_ready_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) bank_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (key_load) begin
            key_q   <= key_in;
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          // key_out has been stable for a cycle, so the schedule is settled.
          for (int i = 0; i <= NUM_ROUNDS; i++) bank_q[i] <= round_keys_in[i*KEY_W +: KEY_W];
          key_ready_q <= 1'b1;
          state_q     <= READY;
        end
        READY: begin
          if (key_load) begin
            key_q       <= key_in;
            key_ready_q <= 1'b0;
            state_q     <= CAPTURE;
          end else if (start) begin
            dir_q       <= decrypt;
            idx_q       <= decrypt ? LAST_IDX : '0;
            valid_q     <= 1'b1;
            key_ready_q <= 1'b0;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (rk_ready) begin
            if (last_key) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q <= dir_q ? idx_q - 1'b1 : idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          key_ready_q <= 1'b1;
          state_q     <= READY;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_out   = key_q;
  assign rk_valid  = valid_q;
  assign rk_data   = valid_q ? bank_q[idx_q] : '0;
  assign rk_round  = valid_q ? idx_q : '0;
  assign key_ready = key_ready_q;
  assign done      = done_q;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Bench for round_key_sequencer: an AES-128 key expansion model feeds the
// schedule input from key_out; streamed keys are checked against a scoreboard.
module tb_round_key_sequencer;

  typedef struct {
    logic [127:0] key;
    logic         dec;
    int           stallPct;
    logic         load;
  } vec_t;

  typedef struct {
    logic [3:0]   round;
    logic [127:0] data;
  } exp_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ALT_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic           clk;
  logic           rst;
  logic           key_load;
  logic [127:0]   key_in;
  logic [127:0]   key_out;
  logic [1407:0]  rkIn;
  logic           start;
  logic           decrypt;
  logic [127:0]   rk_data;
  logic [3:0]     rk_round;
  logic           rk_valid;
  logic           rk_ready;
  logic           key_ready;
  logic           done;

  int             vecCount;
  int             missCount;
  exp_t           sb[$];
  logic [3:0]     obsRound [11];
  logic [127:0]   obsData [11];
  vec_t           vecs [5];

  round_key_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .key_load     (key_load),
    .key_in       (key_in),
    .key_out      (key_out),
    .round_keys_in(rkIn),
    .start        (start),
    .decrypt      (decrypt),
    .rk_data      (rk_data),
    .rk_round     (rk_round),
    .rk_valid     (rk_valid),
    .rk_ready     (rk_ready),
    .key_ready    (key_ready),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    for (int x = 1; x < 256; x++)
      if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expandKey(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 11; n++) r[128*n +: 128] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    return r;
  endfunction

  // Live key schedule driven from the DUT's registered key.
  always_comb rkIn = expandKey(key_out);

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic loadKey(input logic [127:0] k);
    key_load = 1'b1;
    key_in   = k;
    @(negedge clk);
    key_load = 1'b0;
    checkOutput("capture key_ready", 128'(key_ready), 128'd0);
    checkOutput("key_out", key_out, k);
    @(negedge clk);
    checkOutput("ready key_ready", 128'(key_ready), 128'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [1407:0] sched;
    exp_t          e;
    int            cycles;
    int            n;
    sched = expandKey(v.key);
    if (v.load) loadKey(v.key);
    start   = 1'b1;
    decrypt = v.dec;
    for (int i = 0; i < 11; i++) begin
      e.round = v.dec ? 4'(10 - i) : 4'(i);
      e.data  = sched[128*e.round +: 128];
      sb.push_back(e);
    end
    @(negedge clk);
    start   = 1'b0;
    decrypt = ~v.dec;
    cycles  = 0;
    n       = 0;
    while (sb.size() > 0 && cycles < 400) begin
      checkOutput("rk_valid", 128'(rk_valid), 128'd1);
      checkOutput("rk_round", 128'(rk_round), 128'(sb[0].round));
      checkOutput("rk_data", rk_data, sb[0].data);
      rk_ready = (int'($urandom_range(99)) >= v.stallPct);
      if (rk_ready) begin
        obsRound[n] = rk_round;
        obsData[n]  = rk_data;
        n++;
        void'(sb.pop_front());
      end
      @(negedge clk);
      cycles++;
    end
    if (sb.size() > 0) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL stream timeout: got %0d keys left expected 0", sb.size());
      sb.delete();
    end
    rk_ready = 1'b0;
    checkOutput("done pulse", 128'(done), 128'd1);
    checkOutput("valid after last", 128'(rk_valid), 128'd0);
    checkOutput("data idle zero", rk_data, 128'd0);
    checkOutput("round idle zero", 128'(rk_round), 128'd0);
    checkOutput("key_ready in DONE", 128'(key_ready), 128'd0);
    @(negedge clk);
    checkOutput("done single cycle", 128'(done), 128'd0);
    checkOutput("key_ready after DONE", 128'(key_ready), 128'd1);
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    rst       = 1'b1;
    key_load  = 1'b0;
    key_in    = '0;
    start     = 1'b0;
    decrypt   = 1'b0;
    rk_ready  = 1'b0;

    vecs[0] = '{key: FIPS_KEY, dec: 1'b0, stallPct: 0,  load: 1'b1};
    vecs[1] = '{key: FIPS_KEY, dec: 1'b1, stallPct: 0,  load: 1'b0};
    vecs[2] = '{key: FIPS_KEY, dec: 1'b0, stallPct: 50, load: 1'b0};
    vecs[3] = '{key: ALT_KEY,  dec: 1'b1, stallPct: 40, load: 1'b1};
    vecs[4] = '{key: {128{1'b1}}, dec: 1'b0, stallPct: 30, load: 1'b1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset key_ready", 128'(key_ready), 128'd0);
    checkOutput("reset rk_valid", 128'(rk_valid), 128'd0);
    checkOutput("reset done", 128'(done), 128'd0);
    checkOutput("reset rk_data", rk_data, 128'd0);
    checkOutput("reset rk_round", 128'(rk_round), 128'd0);
    checkOutput("reset key_out", key_out, 128'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("idle start ignored", 128'(rk_valid), 128'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      if (i == 0) begin
        checkOutput("enc round1 data", obsData[1], FIPS_RK1);
        checkOutput("enc round10 data", obsData[10], FIPS_RK10);
        checkOutput("enc round10 idx", 128'(obsRound[10]), 128'd10);
      end
      if (i == 1) begin
        checkOutput("dec first idx", 128'(obsRound[0]), 128'd10);
        checkOutput("dec first data", obsData[0], FIPS_RK10);
        checkOutput("dec last idx", 128'(obsRound[10]), 128'd0);
        checkOutput("dec last data", obsData[10], FIPS_KEY);
      end
    end

    // key_load and start together in READY: reload wins, no streaming.
    key_load = 1'b1;
    start    = 1'b1;
    key_in   = ALT_KEY;
    @(negedge clk);
    key_load = 1'b0;
    start    = 1'b0;
    checkOutput("collide rk_valid", 128'(rk_valid), 128'd0);
    checkOutput("collide key_ready", 128'(key_ready), 128'd0);
    checkOutput("collide key_out", key_out, ALT_KEY);
    @(negedge clk);
    checkOutput("collide rk_valid2", 128'(rk_valid), 128'd0);
    checkOutput("collide key_ready2", 128'(key_ready), 128'd1);
    applyStimulus('{key: ALT_KEY, dec: 1'b0, stallPct: 20, load: 1'b0});

    // Reset mid-stream, with key_load and start also asserted on that edge.
    start    = 1'b1;
    decrypt  = 1'b0;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !(rk_valid && rk_round == 4'd5); c++) @(negedge clk);
    checkOutput("reach round 5", 128'(rk_round), 128'd5);
    rst      = 1'b1;
    key_load = 1'b1;
    key_in   = {128{1'b1}};
    start    = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    key_load = 1'b0;
    start    = 1'b0;
    rk_ready = 1'b0;
    checkOutput("rst rk_valid", 128'(rk_valid), 128'd0);
    checkOutput("rst rk_data", rk_data, 128'd0);
    checkOutput("rst rk_round", 128'(rk_round), 128'd0);
    checkOutput("rst key_ready", 128'(key_ready), 128'd0);
    checkOutput("rst done", 128'(done), 128'd0);
    checkOutput("rst priority key_out", key_out, 128'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput("post-rst no stream", 128'(rk_valid), 128'd0);
      checkOutput("post-rst no key_ready", 128'(key_ready), 128'd0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/round_key_sequencer.md
ROUND_KEY_SEQUENCER -- requirements
Module: round_key_sequencer

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, number of the last round key index (AES-128).
REQ-002 SHALL have parameter KEY_W, default 128, width of one round key in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port key_load  input  1  request to accept a new cipher key.
REQ-006 SHALL have port key_in  input  128  cipher key sampled when key_load is accepted.
REQ-007 SHALL have port key_out  output  128  registered cipher key; drives the key schedule's encryptKey input.
REQ-008 SHALL have port round_keys_in  input  1408  key schedule output; round key i at bits [128*i+127:128*i], key 0 at [127:0], key 10 at [1407:1280].
REQ-009 SHALL have port start  input  1  request to stream all round keys.
REQ-010 SHALL have port decrypt  input  1  order select sampled with start: 0 = keys 0..10, 1 = keys 10..0.
REQ-011 SHALL have port rk_data  output  128  current round key.
REQ-012 SHALL have port rk_round  output  4  index of the key on rk_data.
REQ-013 SHALL have port rk_valid  output  1  rk_data/rk_round valid.
REQ-014 SHALL have port rk_ready  input  1  consumer accepts the current key.
REQ-015 SHALL have port key_ready  output  1  key bank holds a complete schedule; start accepted.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the final key is accepted.

Function
REQ-017 SHALL implement states IDLE, CAPTURE, READY, STREAM, DONE.
REQ-018 IDLE: key_load=1 SHALL register key_in into key_out and go to CAPTURE; start SHALL be ignored.
REQ-019 CAPTURE: SHALL latch all 11 slices of round_keys_in into an internal key bank, then go to READY (key_load at cycle N -> key_ready=1 at cycle N+2).
REQ-020 READY: key_ready SHALL be 1; key_load=1 SHALL reload as in REQ-018 (key_ready=0 next cycle); else start=1 SHALL latch decrypt, set index to 0 (decrypt=0) or NUM_ROUNDS (decrypt=1) and go to STREAM.
REQ-021 key_load and start both high in READY: key_load SHALL win; start SHALL be dropped.
REQ-022 STREAM: rk_valid SHALL be 1, rk_data SHALL equal bank[index], rk_round SHALL equal index, first key visible the cycle after start.
REQ-023 rk_valid=1 and rk_ready=0: rk_data and rk_round SHALL hold stable.
REQ-024 rk_valid=1 and rk_ready=1: index SHALL step +1 (encrypt) or -1 (decrypt), one key per cycle with rk_ready held high; no wrap-around.
REQ-025 handshake on index NUM_ROUNDS (encrypt) or 0 (decrypt) SHALL go to DONE; rk_valid=0 next cycle.
REQ-026 DONE: done SHALL be 1 for exactly one cycle, then READY; bank contents retained for further starts.
REQ-027 key_load and start SHALL be ignored in CAPTURE, STREAM and DONE.
REQ-028 key_ready SHALL be 0 in IDLE, CAPTURE, STREAM and DONE.
REQ-029 rk_data and rk_round SHALL be 0 whenever rk_valid=0.
REQ-030 all outputs SHALL be driven from registers or register-selected bank entries; no combinational path from inputs to outputs.

Reset
REQ-031 rst=1 on a clock edge SHALL force IDLE, clear key_out, key bank, index and direction to 0; key_ready, rk_valid, done, rk_data, rk_round SHALL be 0 the following cycle.
REQ-032 rst mid-STREAM or mid-CAPTURE SHALL abandon the operation; a new key_load is required before start is honoured.
REQ-033 rst SHALL take priority over key_load and start in the same cycle.

Verification (bench drives round_keys_in from a live key schedule fed by key_out)
REQ-034 key_load, key_in=2b7e151628aed2a6abf7158809cf4f3c -> key_ready=1 two cycles later; key_out equals key_in.
REQ-035 start, decrypt=0, rk_ready=1 -> 11 consecutive keys, rk_round 0..10, round 1 a0fafe1788542cb123a339392a6c7605, round 10 d014f9a8c9ee2589e13f0cc8b6630ca6, done one cycle after round 10 accepted.
REQ-036 start, decrypt=1 -> first key round 10 d014f9a8..., last round 0 2b7e1516..., rk_round 10..0.
REQ-037 rk_ready toggled randomly -> every key appears exactly once, data stable while stalled, order unchanged.
REQ-038 rst asserted at rk_round=5 -> rk_valid=0 next cycle, state IDLE; start alone -> no rk_valid.
REQ-039 key_load and start together in READY -> no streaming; key_ready low one cycle, high again after CAPTURE with new key's schedule.
